// File: rtl/lia_pkg.sv
// Shared constants and helpers for the lock-in demodulator.
package lia_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_ACC_LOG2 = 10;
    localparam int unsigned DEF_OUT_W    = 32;

    localparam logic [DEF_DATA_W-1:0] REF_ZERO = 16'h8000;

    // Offset binary to two's complement: flipping the MSB recentres 0x8000 onto zero.
    function automatic logic signed [DEF_DATA_W-1:0] ob_to_signed(
        input logic [DEF_DATA_W-1:0] v
    );
        return $signed(v ^ REF_ZERO);
    endfunction

endpackage

// File: rtl/lia_demod_if.sv
// Sample input and result handshake bundle for lia_demod.
interface lia_demod_if #(
    parameter int unsigned DATA_W = lia_pkg::DEF_DATA_W,
    parameter int unsigned OUT_W  = lia_pkg::DEF_OUT_W
) ();

    logic              en;
    logic              sig_valid;
    logic [DATA_W-1:0] sig_in;
    logic [DATA_W-1:0] ref_in;
    logic              x_valid;
    logic              x_ready;
    logic [OUT_W-1:0]  x_out;
    logic              overrun;
    logic              busy;

    modport master (
        output en, sig_valid, sig_in, ref_in, x_ready,
        input  x_valid, x_out, overrun, busy
    );

    modport slave (
        input  en, sig_valid, sig_in, ref_in, x_ready,
        output x_valid, x_out, overrun, busy
    );

endinterface

// File: rtl/lia_mac.sv
// Capture, multiply and block-average datapath; strobes one result per 2^ACC_LOG2 samples.
module lia_mac
    import lia_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ACC_LOG2 = DEF_ACC_LOG2,
    parameter int unsigned OUT_W    = DEF_OUT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic                     i_sig_valid,
    input  logic signed [DATA_W-1:0] i_sig,
    input  logic        [DATA_W-1:0] i_ref,
    output logic                     o_res_valid,
    output logic signed [OUT_W-1:0]  o_res,
    output logic                     o_busy
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ACC_W  = PROD_W + ACC_LOG2;

    logic                       r_v1;
    logic signed [DATA_W-1:0]   r_sig;
    logic signed [DATA_W-1:0]   r_ref;
    logic                       r_v2;
    logic signed [PROD_W-1:0]   r_prod;
    logic signed [ACC_W-1:0]    r_acc;
    logic        [ACC_LOG2-1:0] r_cnt;
    logic                       r_res_valid;
    logic signed [OUT_W-1:0]    r_res;

    logic signed [ACC_W-1:0]    w_sum;
    logic signed [ACC_W-1:0]    w_avg;
    logic                       w_last;

    assign w_sum  = r_acc + ACC_W'(r_prod);
    assign w_avg  = w_sum >>> ACC_LOG2;
    assign w_last = &r_cnt;

    // Dropping en flushes the pipeline so a partial block can never leak into a result.
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_v1 <= i_sig_valid;
            if (i_sig_valid) begin
                r_sig <= i_sig;
                r_ref <= ob_to_signed(i_ref);
            end
            r_v2 <= r_v1;
            if (r_v1) begin
                r_prod <= PROD_W'(r_sig) * PROD_W'(r_ref);
            end
            r_res_valid <= r_v2 && w_last;
            if (r_v2) begin
                if (w_last) begin
                    r_acc <= '0;
                    r_res <= OUT_W'(w_avg);
                end else begin
                    r_acc <= w_sum;
                end
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_res_valid = r_res_valid;
    assign o_res       = r_res;
    assign o_busy      = (r_cnt != '0) || r_v1 || r_v2 || r_res_valid;

endmodule

// File: rtl/lia_demod.sv
// Lock-in demodulator top: block-averaged sig*ref behind a registered valid/ready output.
module lia_demod
    import lia_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ACC_LOG2 = DEF_ACC_LOG2,
    parameter int unsigned OUT_W    = DEF_OUT_W
) (
    input logic        clk,
    input logic        rst,
    lia_demod_if.slave bus
);

    logic                    w_res_valid;
    logic signed [OUT_W-1:0] w_res;
    logic                    w_busy;

    logic                    r_x_valid;
    logic        [OUT_W-1:0] r_x_out;
    logic                    r_overrun;

    lia_mac #(
        .DATA_W   (DATA_W),
        .ACC_LOG2 (ACC_LOG2),
        .OUT_W    (OUT_W)
    ) u_mac (
        .clk         (clk),
        .rst         (rst),
        .i_en        (bus.en),
        .i_sig_valid (bus.sig_valid),
        .i_sig       ($signed(bus.sig_in)),
        .i_ref       (bus.ref_in),
        .o_res_valid (w_res_valid),
        .o_res       (w_res),
        .o_busy      (w_busy)
    );

    // A held result is never overwritten; a colliding new one is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_valid <= 1'b0;
            r_x_out   <= '0;
            r_overrun <= 1'b0;
        end else if (w_res_valid) begin
            if (!r_x_valid || bus.x_ready) begin
                r_x_out   <= w_res;
                r_x_valid <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_x_valid && bus.x_ready) begin
            r_x_valid <= 1'b0;
        end
    end

    assign bus.x_valid = r_x_valid;
    assign bus.x_out   = r_x_out;
    assign bus.overrun = r_overrun;
    assign bus.busy    = w_busy;

endmodule

// File: tb/tb_lia_demod.sv
// Directed bench for lia_demod with N = 4 samples per block.
module tb_lia_demod;

    localparam int unsigned DW = 16;
    localparam int unsigned AL = 2;
    localparam int unsigned OW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    lia_demod_if #(.DATA_W(DW), .OUT_W(OW)) bus ();

    lia_demod #(
        .DATA_W   (DW),
        .ACC_LOG2 (AL),
        .OUT_W    (OW)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic signed [DW-1:0] s, input logic [DW-1:0] r);
        bus.sig_valid = 1'b1;
        bus.sig_in    = s;
        bus.ref_in    = r;
        tick();
        bus.sig_valid = 1'b0;
    endtask

    task automatic consume();
        bus.x_ready = 1'b1;
        tick();
        bus.x_ready = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.x_valid && n < 10) begin
            tick();
            n++;
        end
        check_eq({tag, "_valid"}, longint'(bus.x_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en        = 1'b0;
        bus.sig_valid = 1'b0;
        bus.sig_in    = '0;
        bus.ref_in    = 16'h8000;
        bus.x_ready   = 1'b0;
        rst           = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_valid", longint'(bus.x_valid), 0);
        check_eq("rst_out", longint'(bus.x_out), 0);
        check_eq("rst_overrun", longint'(bus.overrun), 0);
        check_eq("rst_busy", longint'(bus.busy), 0);

        // Basic average and latency
        bus.en = 1'b1;
        repeat (4) send(16'sd1000, 16'hFFFF);
        check_eq("t1_busy_run", longint'(bus.busy), 1);
        tick();
        check_eq("t1_lat1", longint'(bus.x_valid), 0);
        tick();
        check_eq("t1_lat2", longint'(bus.x_valid), 0);
        tick();
        check_eq("t1_lat3", longint'(bus.x_valid), 1);
        check_eq("t1_out", $signed(bus.x_out), 32767000);
        check_eq("t1_busy_done", longint'(bus.busy), 0);
        consume();
        check_eq("t1_consumed", longint'(bus.x_valid), 0);

        // Sign and floor
        send(-16'sd1, 16'h8001);
        repeat (3) send(16'sd0, 16'h8001);
        wait_valid("t2a");
        check_eq("t2a_out", $signed(bus.x_out), -1);
        consume();
        repeat (4) send(-16'sd2, 16'h8001);
        wait_valid("t2b");
        check_eq("t2b_out", $signed(bus.x_out), -2);
        consume();

        // Extremes with gaps between valid samples
        repeat (3) begin
            send(-16'sd32768, 16'h0000);
            tick();
            tick();
        end
        repeat (4) tick();
        check_eq("t3_early", longint'(bus.x_valid), 0);
        send(-16'sd32768, 16'h0000);
        wait_valid("t3");
        check_eq("t3_out", $signed(bus.x_out), 1073741824);
        consume();

        // Back-to-back blocks, consumer stalled
        check_eq("t4_overrun_pre", longint'(bus.overrun), 0);
        repeat (4) send(16'sd100, 16'h8001);
        repeat (4) send(16'sd200, 16'h8001);
        repeat (4) tick();
        check_eq("t4_valid", longint'(bus.x_valid), 1);
        check_eq("t4_held", $signed(bus.x_out), 100);
        check_eq("t4_overrun", longint'(bus.overrun), 1);
        consume();
        check_eq("t4_consumed", longint'(bus.x_valid), 0);
        check_eq("t4_sticky", longint'(bus.overrun), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t4_ovr_clr", longint'(bus.overrun), 0);

        // Accept in the same cycle the second result arrives
        repeat (4) send(16'sd300, 16'h8001);
        repeat (4) send(16'sd400, 16'h8001);
        tick();
        tick();
        check_eq("t5_first", $signed(bus.x_out), 300);
        bus.x_ready = 1'b1;
        tick();
        bus.x_ready = 1'b0;
        check_eq("t5_valid", longint'(bus.x_valid), 1);
        check_eq("t5_second", $signed(bus.x_out), 400);
        check_eq("t5_overrun", longint'(bus.overrun), 0);
        consume();
        check_eq("t5_consumed", longint'(bus.x_valid), 0);

        // Abort via en, partial block discarded
        repeat (2) send(16'sd999, 16'hFFFF);
        bus.en = 1'b0;
        tick();
        tick();
        check_eq("t6_idle_busy", longint'(bus.busy), 0);
        bus.en = 1'b1;
        repeat (4) send(16'sd10, 16'h8002);
        wait_valid("t6");
        check_eq("t6_out", $signed(bus.x_out), 20);
        consume();

        // Reset mid-block with a result still held
        repeat (4) send(16'sd50, 16'h8001);
        wait_valid("t7_pre");
        repeat (2) send(16'sd999, 16'hFFFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t7_valid", longint'(bus.x_valid), 0);
        check_eq("t7_out", longint'(bus.x_out), 0);
        check_eq("t7_overrun", longint'(bus.overrun), 0);
        check_eq("t7_busy", longint'(bus.busy), 0);
        repeat (4) send(16'sd7, 16'h8003);
        wait_valid("t7_post");
        check_eq("t7_post_out", $signed(bus.x_out), 21);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
